// File: rtl/weight_loader.sv
// Streams NUM_UNITS weight bytes from a valid/ready source into a register bank,
// one registered write per accepted byte, then pulses done for a single cycle.
module weight_loader #(
    parameter int DATA_W    = 8,
    parameter int NUM_UNITS = 4,
    parameter int ADDR_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] inData,
    input  logic              inValid,
    output logic              inReady,
    output logic [DATA_W-1:0] dataIn,
    output logic [ADDR_W-1:0] address,
    output logic              write,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(NUM_UNITS - 1);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] data_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic              write_r;
    logic              write_nxt_s;
    logic              busy_r;
    logic              busy_nxt_s;
    logic              done_r;
    logic              done_nxt_s;
    logic              ready_s;
    logic              transfer_s;

    // Ready is a pure decode of the current state so the source sees it without delay.
    assign ready_s    = (state_r == LOAD);
    assign transfer_s = ready_s & inValid;

    // Next-state, counter and bank-port decisions for the coming edge.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        data_nxt_s  = data_r;
        addr_nxt_s  = addr_r;
        write_nxt_s = 1'b0;
        done_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = LOAD;
                    cnt_nxt_s   = {ADDR_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (transfer_s) begin
                    data_nxt_s  = inData;
                    addr_nxt_s  = cnt_r;
                    write_nxt_s = 1'b1;
                    // The last byte wraps the counter so it never leaves 0..NUM_UNITS-1.
                    if (cnt_r == LAST_CNT) begin
                        state_nxt_s = FINISH;
                        cnt_nxt_s   = {ADDR_W{1'b0}};
                    end else begin
                        state_nxt_s = LOAD;
                        cnt_nxt_s   = cnt_r + ADDR_W'(1);
                    end
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            FINISH: begin
                state_nxt_s = IDLE;
                done_nxt_s  = 1'b1;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {ADDR_W{1'b0}};
            end
        endcase
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // State and registered outputs; reset clears everything without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {ADDR_W{1'b0}};
            data_r  <= {DATA_W{1'b0}};
            addr_r  <= {ADDR_W{1'b0}};
            write_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            data_r  <= data_nxt_s;
            addr_r  <= addr_nxt_s;
            write_r <= write_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign inReady = ready_s;
    assign dataIn  = data_r;
    assign address = addr_r;
    assign write   = write_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: directed scenarios plus randomized traffic
// compared every cycle against a behavioural sequence model.
module tb_weight_loader;

    localparam int DATA_W    = 8;
    localparam int NUM_UNITS = 4;
    localparam int ADDR_W    = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] inData;
    logic              inValid;
    logic              inReady;
    logic [DATA_W-1:0] dataIn;
    logic [ADDR_W-1:0] address;
    logic              write;
    logic              busy;
    logic              done;

    weight_loader #(.DATA_W(DATA_W), .NUM_UNITS(NUM_UNITS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .inData(inData), .inValid(inValid),
        .inReady(inReady), .dataIn(dataIn), .address(address), .write(write),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: "accepting" while a sequence is collecting bytes,
    // "closing" for the one cycle after the final byte was taken.
    bit              m_accepting;
    bit              m_closing;
    int              m_taken;
    bit              m_write;
    bit              m_done;
    int              m_data;
    int              m_addr;
    int              m_done_total;

    int waddr[$];
    int wdata[$];
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_accepting = 1'b0;
        m_closing   = 1'b0;
        m_taken     = 0;
        m_write     = 1'b0;
        m_done      = 1'b0;
        m_data      = 0;
        m_addr      = 0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else if (m_accepting) begin
            m_done = 1'b0;
            if (inValid) begin
                m_write = 1'b1;
                m_data  = int'(inData);
                m_addr  = m_taken;
                m_taken = m_taken + 1;
                if (m_taken == NUM_UNITS) begin
                    m_accepting = 1'b0;
                    m_closing   = 1'b1;
                    m_taken     = 0;
                end
            end else begin
                m_write = 1'b0;
            end
        end else if (m_closing) begin
            m_closing = 1'b0;
            m_write   = 1'b0;
            m_done    = 1'b1;
            m_done_total++;
        end else begin
            m_write = 1'b0;
            m_done  = 1'b0;
            if (start) begin
                m_accepting = 1'b1;
                m_taken     = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".write"},   32'(write),   32'(m_write));
        check({tag, ".done"},    32'(done),    32'(m_done));
        check({tag, ".busy"},    32'(busy),    32'(m_accepting | m_closing));
        check({tag, ".dataIn"},  32'(dataIn),  32'(m_data));
        check({tag, ".address"}, 32'(address), 32'(m_addr));
    endtask

    // One clock cycle: entered and left at the falling edge with inputs already driven.
    task automatic tick();
        #1;
        check("inReady", 32'(inReady), 32'(m_accepting));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs("cyc");
        if (write === 1'b1) begin
            waddr.push_back(int'(address));
            wdata.push_back(int'(dataIn));
        end
        if (done === 1'b1) done_cnt++;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] b, input int gap);
        inValid = 1'b1;
        inData  = b;
        tick();
        inValid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic clear_log();
        waddr.delete();
        wdata.delete();
    endtask

    // Compares the captured bank writes against hand-written (address, byte) pairs.
    task automatic check_log(input string name, input int n, input int exp_a[8], input int exp_d[8]);
        check({name, ".count"}, 32'(waddr.size()), 32'(n));
        for (int i = 0; i < n && i < waddr.size(); i++) begin
            check({name, ".addr"}, 32'(waddr[i]), 32'(exp_a[i]));
            check({name, ".data"}, 32'(wdata[i]), 32'(exp_d[i]));
        end
    endtask

    int bytes_a[4];
    int seq_a[8];
    int seq_d[8];
    int done_before;

    initial begin
        bytes_a = '{32'h11, 32'h22, 32'h33, 32'h44};
        seq_a   = '{0, 1, 2, 3, 0, 1, 2, 3};
        seq_d   = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h11, 32'h22, 32'h33, 32'h44};
        m_done_total = 0;
        reset   = 1'b1;
        start   = 1'b0;
        inValid = 1'b0;
        inData  = '0;
        model_reset();
        @(negedge clk);
        tick();
        check("reset.write", 32'(write), 32'h0);
        check("reset.busy",  32'(busy),  32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Valid data while idle must not be consumed.
        inValid = 1'b1;
        inData  = 8'h55;
        repeat (3) tick();
        inValid = 1'b0;
        check("idle_no_xfer", 32'(waddr.size()), 32'h0);
        check("idle_ready",   32'(inReady),      32'h0);

        // Back-to-back load.
        clear_log();
        done_before = done_cnt;
        pulse_start();
        for (int i = 0; i < 4; i++) send(8'(bytes_a[i]), 0);
        repeat (3) tick();
        check_log("b2b", 4, seq_a, seq_d);
        check("b2b.done_pulses", 32'(done_cnt - done_before), 32'h1);
        check("b2b.busy_after",  32'(busy), 32'h0);

        // Three idle cycles between bytes.
        clear_log();
        done_before = done_cnt;
        pulse_start();
        for (int i = 0; i < 4; i++) send(8'(bytes_a[i]), 3);
        repeat (2) tick();
        check_log("gaps", 4, seq_a, seq_d);
        check("gaps.done_pulses", 32'(done_cnt - done_before), 32'h1);

        // Start during LOAD is ignored.
        clear_log();
        done_before = done_cnt;
        pulse_start();
        send(8'h11, 0);
        send(8'h22, 0);
        pulse_start();
        send(8'h33, 0);
        send(8'h44, 0);
        repeat (3) tick();
        check_log("start_in_load", 4, seq_a, seq_d);
        check("start_in_load.done_pulses", 32'(done_cnt - done_before), 32'h1);

        // Asynchronous reset in the middle of a sequence.
        clear_log();
        done_before = done_cnt;
        pulse_start();
        send(8'hAA, 0);
        send(8'hBB, 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("midrst.write",   32'(write),   32'h0);
        check("midrst.busy",    32'(busy),    32'h0);
        check("midrst.address", 32'(address), 32'h0);
        check("midrst.dataIn",  32'(dataIn),  32'h0);
        check("midrst.inReady", 32'(inReady), 32'h0);
        tick();
        reset = 1'b0;
        inValid = 1'b1;
        inData  = 8'hCC;
        repeat (2) tick();
        inValid = 1'b0;
        check("midrst.no_done", 32'(done_cnt - done_before), 32'h0);
        check("midrst.pre_writes", 32'(waddr.size()), 32'h2);
        clear_log();
        pulse_start();
        for (int i = 0; i < 4; i++) send(8'(bytes_a[i]), 0);
        repeat (2) tick();
        check_log("after_rst", 4, seq_a, seq_d);

        // Start in the done cycle chains a second sequence.
        clear_log();
        done_before = done_cnt;
        pulse_start();
        for (int i = 0; i < 4; i++) send(8'(bytes_a[i]), 0);
        tick();
        check("chain.done_now", 32'(done), 32'h1);
        pulse_start();
        for (int i = 0; i < 4; i++) send(8'(bytes_a[i]), 0);
        repeat (3) tick();
        check_log("chain", 8, seq_a, seq_d);
        check("chain.done_pulses", 32'(done_cnt - done_before), 32'h2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                model_reset();
            end
            start   = ($urandom_range(0, 7) == 0);
            inValid = $urandom_range(0, 1) == 1;
            inData  = 8'($urandom);
            tick();
        end
        reset   = 1'b0;
        start   = 1'b0;
        inValid = 1'b0;
        repeat (4) tick();
        check("total_done", 32'(done_cnt), 32'(m_done_total));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter DATA_W, default 8, weight byte width; it SHALL match the weight register bank data width.
REQ-002 Parameter NUM_UNITS, default 4, number of weight registers loaded per sequence.
REQ-003 Parameter ADDR_W, default 2, address width; it SHALL satisfy 2**ADDR_W >= NUM_UNITS.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a load sequence.
REQ-007 inData  input  DATA_W  weight byte from the upstream source.
REQ-008 inValid  input  1  inData is valid this cycle.
REQ-009 inReady  output  1  loader accepts inData this cycle.
REQ-010 dataIn  output  DATA_W  byte driven to the bank data port.
REQ-011 address  output  ADDR_W  bank register select.
REQ-012 write  output  1  bank write strobe.
REQ-013 busy  output  1  a load sequence is in progress.
REQ-014 done  output  1  one-cycle pulse on sequence completion.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, LOAD and FINISH.
REQ-016 inReady SHALL be combinational and equal (state == LOAD); it SHALL be 0 in IDLE and FINISH.
REQ-017 A transfer SHALL occur on a rising edge where inValid = 1 and inReady = 1.
REQ-018 IDLE with start = 1 SHALL go to LOAD on the next edge and clear the word counter cnt to 0.
REQ-019 start SHALL be ignored in LOAD and FINISH, with no effect on cnt, state or outputs.
REQ-020 On each transfer, dataIn <= inData, address <= cnt and write <= 1 SHALL be registered, so the write is visible in the cycle after acceptance.
REQ-021 On an edge with no transfer, write SHALL be 0 and dataIn and address SHALL hold their previous values.
REQ-022 Back-to-back transfers SHALL be supported at one per cycle; write may stay high on consecutive cycles, with address incrementing each cycle.
REQ-023 On a transfer with cnt < NUM_UNITS-1, cnt SHALL increment by 1 and the state SHALL remain LOAD.
REQ-024 On a transfer with cnt = NUM_UNITS-1, the state SHALL go to FINISH and cnt SHALL go to 0; cnt SHALL never exceed NUM_UNITS-1.
REQ-025 In FINISH, the next edge SHALL set write = 0 and done = 1 and SHALL return the state to IDLE.
REQ-026 done SHALL be high for exactly one cycle, the cycle after the last write cycle; it SHALL be 0 otherwise.
REQ-027 busy SHALL be registered and high exactly while the state is LOAD or FINISH.
REQ-028 inValid with inReady = 0 SHALL NOT cause a transfer, and the byte SHALL NOT be consumed.
REQ-029 start in the done cycle (state IDLE) SHALL begin a new sequence normally.
REQ-030 Idle gaps in inValid during LOAD SHALL stall the sequence indefinitely with write = 0; no timeout SHALL apply.

Reset
REQ-031 While reset = 1, state = IDLE, cnt = 0, dataIn = 0, address = 0, write = 0, busy = 0, done = 0 and inReady = 0, independent of clk.
REQ-032 Reset during LOAD or FINISH SHALL abort the sequence without a done pulse; no write SHALL issue after reset asserts; bank contents already written remain.
REQ-033 After reset deasserts, the loader SHALL require a new start before accepting data.

Verification
REQ-034 Reset, then start, then inData 0x11, 0x22, 0x33, 0x44 on consecutive cycles with inValid = 1 -> write high on 4 consecutive cycles with (address, dataIn) = (0,0x11), (1,0x22), (2,0x33), (3,0x44); done pulses for 1 cycle after; busy = 0 after done.
REQ-035 The same bytes with inValid low for 3 cycles between every byte -> identical write sequence; write = 0 during gaps; busy stays 1 throughout.
REQ-036 start pulsed during LOAD after 2 bytes -> ignored; the remaining bytes go to addresses 2 and 3; exactly one done pulse.
REQ-037 reset asserted mid-cycle after 2 transfers of 0xAA, 0xBB -> all outputs 0 immediately; no done pulse; the next start and 4 bytes load addresses 0..3 from 0.
REQ-038 inValid = 1 with 0x55 while IDLE with no start -> inReady = 0 and write = 0; no transfer occurs.
REQ-039 start asserted in the done cycle, then 4 bytes -> the second sequence writes addresses 0..3 with no lost or duplicated write.
